pwm_duty_decoder: RTL and testbench

Receive-side counterpart of the fan/LED PWM generators. It samples an external PWM waveform and measures the period and high time in clk cycles. It then computes the duty ratio in per-mille (0..1000, the same scale the generators take as input) and reports each result with a one-cycle valid strobe. It is used for closed-loop checking of the fan and RGB channels and for reading external tach/PWM sources.

---
 rtl/pwm_duty_decoder.sv | 189 ++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// PWM receiver: measures period and high time of an external PWM input and
// reports duty in per-mille through a sequential restoring divider.
module pwm_duty_decoder #(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned TIMEOUT = 1048575
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             pwm_in,
  output logic [9:0]       duty_permille,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             busy
);

  localparam int unsigned NUM_W  = CNT_W + 10;
  localparam int unsigned STEP_W = $clog2(NUM_W + 1);

  typedef enum logic {WAIT_RISE, MEASURE} state_t;

  // Input synchronizer and edge detector
  logic [1:0] sync_q;
  logic       lvl_q;
  logic       level_c;
  logic       rise_c;
  logic       fall_c;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync_q <= 2'b00;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
      lvl_q  <= sync_q[1];
    end
  end

  assign level_c = sync_q[1];
  assign rise_c  = level_c & ~lvl_q;
  assign fall_c  = ~level_c & lvl_q;

  // Measurement FSM
  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             fall_seen_q, fall_seen_d;
  logic             load_c;
  logic             timeout_c;
  logic             clear_stuck_c;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q      <= WAIT_RISE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      fall_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      fall_seen_q  <= fall_seen_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    fall_seen_d   = fall_seen_q;
    load_c        = 1'b0;
    timeout_c     = 1'b0;
    clear_stuck_c = 1'b0;
    case (state_q)
      WAIT_RISE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        fall_seen_d  = 1'b0;
        if (rise_c) begin
          state_d       = MEASURE;
          period_cnt_d  = CNT_W'(1);
          high_cnt_d    = CNT_W'(1);
          clear_stuck_c = 1'b1;
        end
      end
      MEASURE: begin
        if (rise_c) begin
          // A busy divider drops the sample; the counters restart regardless.
          load_c        = ~busy;
          period_cnt_d  = CNT_W'(1);
          high_cnt_d    = CNT_W'(1);
          fall_seen_d   = 1'b0;
          clear_stuck_c = 1'b1;
        end else if (period_cnt_q == CNT_W'(TIMEOUT)) begin
          timeout_c    = 1'b1;
          state_d      = WAIT_RISE;
          period_cnt_d = '0;
          high_cnt_d   = '0;
          fall_seen_d  = 1'b0;
        end else begin
          period_cnt_d = period_cnt_q + CNT_W'(1);
          if (fall_c) begin
            fall_seen_d = 1'b1;
          end else if (level_c && !fall_seen_q) begin
            high_cnt_d = high_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = WAIT_RISE;
    endcase
  end

  // Restoring divider: quo_q shifts the numerator out and the quotient in
  logic [STEP_W-1:0] step_q;
  logic [CNT_W-1:0]  den_q;
  logic [CNT_W-1:0]  rem_q;
  logic [NUM_W-1:0]  quo_q;
  logic [CNT_W:0]    rem_shift_c;
  logic [CNT_W:0]    sub_c;
  logic              q_bit_c;
  logic [CNT_W-1:0]  rem_next_c;
  logic [NUM_W-1:0]  quo_next_c;
  logic [9:0]        duty_clamp_c;
  logic              div_done_c;

  // Remainder stays below den, so a nonnegative difference never sets the top bit.
  assign rem_shift_c  = {rem_q, quo_q[NUM_W-1]};
  assign sub_c        = rem_shift_c - {1'b0, den_q};
  assign q_bit_c      = ~sub_c[CNT_W];
  assign rem_next_c   = q_bit_c ? sub_c[CNT_W-1:0] : rem_shift_c[CNT_W-1:0];
  assign quo_next_c   = {quo_q[NUM_W-2:0], q_bit_c};
  assign duty_clamp_c = (quo_next_c > NUM_W'(1000)) ? 10'd1000 : quo_next_c[9:0];
  assign div_done_c   = busy && (step_q == STEP_W'(NUM_W - 1));

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      busy   <= 1'b0;
      step_q <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (busy) begin
      rem_q <= rem_next_c;
      quo_q <= quo_next_c;
      if (div_done_c) begin
        busy   <= 1'b0;
        step_q <= '0;
      end else begin
        step_q <= step_q + STEP_W'(1);
      end
    end else if (load_c) begin
      busy   <= 1'b1;
      step_q <= '0;
      den_q  <= period_cnt_q;
      rem_q  <= '0;
      quo_q  <= NUM_W'(high_cnt_q) * NUM_W'(1000);
    end
  end

  // Result registers; a timeout takes precedence over a finishing divide
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      duty_permille <= '0;
      period        <= '0;
      valid         <= 1'b0;
      stuck_high    <= 1'b0;
      stuck_low     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (timeout_c) begin
        valid         <= 1'b1;
        period        <= '0;
        duty_permille <= level_c ? 10'd1000 : 10'd0;
        stuck_high    <= level_c;
        stuck_low     <= ~level_c;
      end else if (div_done_c) begin
        valid         <= 1'b1;
        period        <= den_q;
        duty_permille <= duty_clamp_c;
      end
      if (clear_stuck_c) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: table segments, random PWM trains and hand
// sequences, all checked against a rise-time based reference model.
module tb_pwm_duty_decoder;

  localparam int unsigned CNT_W = 20;
  localparam int          TMO   = 4095;
  localparam int          MAXC  = 65536;

  logic             clk = 1'b0;
  logic             reset_p;
  logic             pwm_in;
  logic [9:0]       duty_permille;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             stuck_high;
  logic             stuck_low;
  logic             busy;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_p(reset_p), .pwm_in(pwm_in),
    .duty_permille(duty_permille), .period(period), .valid(valid),
    .stuck_high(stuck_high), .stuck_low(stuck_low), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit p_hist [MAXC];

  typedef struct {int edge_no; int duty; int per;} exp_t;
  exp_t expq[$];
  bit   measuring = 1'b0;
  int   last_e    = 0;
  int   div_free  = 0;
  bit   exp_sh    = 1'b0;
  bit   exp_sl    = 1'b0;

  int seg_valids    = 0;
  int stuck_valids  = 0;
  int seg_last_duty = -1;
  int seg_last_per  = -1;

  typedef struct {int per; int hi; int reps; int exp_duty; int exp_per; int exp_n;} vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic bit ph(input int i);
    return (i >= 0 && i < MAXC) ? p_hist[i] : 1'b0;
  endfunction

  function automatic int high_run(input int k, input int lim);
    int n = 0;
    while (k + n < lim && ph(k + n)) n++;
    return n;
  endfunction

  // pwm_in as sampled at each rising edge; held at 0 while in reset
  always @(posedge clk) begin
    cyc++;
    if (cyc < MAXC) p_hist[cyc] = reset_p ? 1'b0 : pwm_in;
  end

  // Reference model: a rise sampled at edge k is acted on at edge k+2
  always @(negedge clk) begin
    if (reset_p) begin
      measuring = 1'b0;
      expq.delete();
      div_free  = 0;
      exp_sh    = 1'b0;
      exp_sl    = 1'b0;
    end else if (cyc >= 3) begin
      int  e;
      bit  rise;
      bit  exp_now;
      e    = cyc;
      rise = ph(e - 2) && !ph(e - 3);
      if (rise) begin
        if (measuring && e >= div_free) begin
          int per, hi, duty;
          per  = e - last_e;
          hi   = high_run(last_e - 2, e - 2);
          duty = (hi * 1000) / per;
          if (duty > 1000) duty = 1000;
          expq.push_back('{e + 30, duty, per});
          div_free = e + 31;
        end
        measuring = 1'b1;
        last_e    = e;
        exp_sh    = 1'b0;
        exp_sl    = 1'b0;
      end else if (measuring && (e - last_e) == TMO) begin
        bit lvl;
        lvl = ph(e - 2);
        expq.push_back('{e, lvl ? 1000 : 0, 0});
        exp_sh    = lvl;
        exp_sl    = !lvl;
        measuring = 1'b0;
      end
      while (expq.size() > 0 && expq[0].edge_no < e) begin
        chk("missed_valid", 0, 1);
        void'(expq.pop_front());
      end
      exp_now = (expq.size() > 0) && (expq[0].edge_no == e);
      if (valid || exp_now) begin
        chk("valid", int'(valid), int'(exp_now));
        if (valid && exp_now) begin
          chk("duty", int'(duty_permille), expq[0].duty);
          chk("period", int'(period), expq[0].per);
        end
        if (exp_now) void'(expq.pop_front());
      end
      if (valid) begin
        if (period != '0) begin
          seg_valids++;
          seg_last_duty = int'(duty_permille);
          seg_last_per  = int'(period);
        end else begin
          stuck_valids++;
        end
      end
      chk("busy", int'(busy), int'(e <= div_free - 2));
      chk("stuck", int'({stuck_high, stuck_low}), int'({exp_sh, exp_sl}));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit v, input int n);
    pwm_in = v;
    tick(n);
  endtask

  task automatic pwm_periods(input int per, input int hi, input int reps);
    repeat (reps) begin
      drive(1'b1, hi);
      drive(1'b0, per - hi);
    end
  endtask

  task automatic clear_stats();
    seg_valids    = 0;
    stuck_valids  = 0;
    seg_last_duty = -1;
    seg_last_per  = -1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_duty"}, int'(duty_permille), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_flags"}, int'({valid, stuck_high, stuck_low, busy}), 0);
  endtask

  initial begin
    tbl[0] = '{100,  33,  10, 330, 100,  9};
    tbl[1] = '{1000, 999, 3,  999, 1000, 2};
    tbl[2] = '{20,   10,  9,  500, 20,   4};
    tbl[3] = '{200,  1,   5,  5,   200,  4};
    tbl[4] = '{37,   12,  6,  324, 37,   5};

    reset_p = 1'b1;
    pwm_in  = 1'b0;
    tick(3);
    chk_zero_outputs("reset");
    reset_p = 1'b0;
    tick(5);

    // Table segments, each ended by an idle-low timeout
    for (int i = 0; i < 5; i++) begin
      clear_stats();
      pwm_periods(tbl[i].per, tbl[i].hi, tbl[i].reps);
      drive(1'b0, TMO + 40);
      chk("tbl_count", seg_valids, tbl[i].exp_n);
      chk("tbl_duty", seg_last_duty, tbl[i].exp_duty);
      chk("tbl_period", seg_last_per, tbl[i].exp_per);
      chk("tbl_stuck_valids", stuck_valids, 1);
      chk("tbl_stuck_low", int'(stuck_low), 1);
    end

    // Random back-to-back trains, including periods below the divider minimum
    for (int s = 0; s < 8; s++) begin
      int per, hi;
      per = int'($urandom_range(8, 400));
      hi  = int'($urandom_range(1, per - 1));
      pwm_periods(per, hi, 4);
    end
    drive(1'b0, TMO + 40);
    chk("rand_stuck_low", int'(stuck_low), 1);

    // Held high past the timeout, then normal operation resumes
    clear_stats();
    drive(1'b0, 5);
    drive(1'b1, 5000);
    chk("sh_flag", int'(stuck_high), 1);
    chk("sh_duty", int'(duty_permille), 1000);
    chk("sh_period", int'(period), 0);
    chk("sh_valids", stuck_valids, 1);
    drive(1'b0, 10);
    pwm_periods(100, 50, 3);
    tick(40);
    chk("sh_cleared", int'(stuck_high), 0);
    chk("sh_after_count", seg_valids, 2);
    chk("sh_after_duty", seg_last_duty, 500);
    chk("sh_after_period", seg_last_per, 100);
    drive(1'b0, TMO + 40);

    // Reset ten cycles into a divide
    pwm_periods(100, 40, 3);
    drive(1'b1, 12);
    chk("pre_reset_busy", int'(busy), 1);
    chk("pre_reset_duty", int'(duty_permille), 400);
    reset_p = 1'b1;
    pwm_in  = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    tick(3);
    reset_p = 1'b0;
    clear_stats();
    tick(5);
    pwm_periods(100, 40, 1);
    chk("post_reset_no_valid", seg_valids + stuck_valids, 0);
    pwm_periods(100, 40, 2);
    tick(40);
    chk("post_reset_count", seg_valids, 2);
    chk("post_reset_duty", seg_last_duty, 400);
    drive(1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
